// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Optional feature macro: CLOCK_DIV_MULTI_SYNC_EN (see clock_div_multi).
package clock_div_pkg;

    // Default width of each channel's division factor
    localparam int DIV_WIDTH_DEF = 8;

    // Factors below this value put a channel into clk_in bypass
    localparam int unsigned BYPASS_THR = 2;

    // Output source selected by a channel's registered mode
    typedef enum logic {
        MODE_DIV = 1'b0,
        MODE_BYP = 1'b1
    } chan_mode_e;

    // Length of the high phase for factor a: ceil(a/2)
    function automatic int unsigned half_high(input int unsigned a);
        return (a >> 1) + (a & 32'd1);
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, active/pending factor with busy flag,
// registered clock/tick outputs and the clk_in bypass mux.
// New factors only take effect at a period boundary (or on sync), so the
// waveform never shows a truncated high or low phase.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int          DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    input  logic                 sync,
    output logic                 busy,
    output logic                 clk_out,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] A_RESET = DIV_WIDTH'(DIV_RESET);

    logic [DIV_WIDTH-1:0] act_q, act_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 is_byp;
    logic                 at_bound;
    logic                 apply;

    logic                 clk_p1;
    logic                 tick_p1;
    chan_mode_e           mode_p1;

    assign is_byp   = 32'(act_q) < BYPASS_THR;
    assign at_bound = !is_byp && (cnt_q == act_q - ONE);

    // Next-state: counter wrap, pending-factor apply and load capture
    always_comb begin
        act_d  = act_q;
        pend_d = pend_q;
        busy_d = busy_q;
        cnt_d  = cnt_q + ONE;
        apply  = 1'b0;
        if (sync || is_byp || at_bound) begin
            cnt_d = '0;
            apply = busy_q;
        end
        if (apply) begin
            act_d  = pend_q;
            busy_d = 1'b0;
        end
        // A load on the apply cycle stays pending for the next boundary
        if (load) begin
            pend_d = div;
            busy_d = 1'b1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            act_q  <= A_RESET;
            pend_q <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---- stage p1: outputs registered one cycle behind the counter ----
    // The mode register delays the bypass switch so the last divided phase
    // is shown in full before the mux hands over to clk_in (and vice versa).
    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_p1  <= 1'b0;
            tick_p1 <= 1'b0;
            mode_p1 <= (DIV_RESET < BYPASS_THR) ? MODE_BYP : MODE_DIV;
        end else begin
            clk_p1  <= !is_byp && (32'(cnt_q) < half_high(32'(act_q)));
            tick_p1 <= !is_byp && (cnt_q == '0);
            mode_p1 <= is_byp ? MODE_BYP : MODE_DIV;
        end
    end

    assign clk_out = (mode_p1 == MODE_BYP) ? clk_in : clk_p1;
    assign tick    = (mode_p1 == MODE_BYP) | tick_p1;
    assign busy    = busy_q;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: N_CH independent integer dividers
// of clk_in with near-50% duty cycle and boundary-aligned reprogramming.
// Optional macro CLOCK_DIV_MULTI_SYNC_EN: when defined, 'sync' restarts every
// channel's period (applying any pending factor) for cross-channel alignment;
// when undefined, 'sync' is ignored and the alignment logic folds away.
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [N_CH*DIV_WIDTH-1:0] div,
    input  logic [N_CH-1:0]           load,
    input  logic                      sync,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           clk_out,
    output logic [N_CH-1:0]           tick
);

    logic sync_int;

`ifdef CLOCK_DIV_MULTI_SYNC_EN
    assign sync_int = sync;
`else
    logic sync_unused;
    assign sync_unused = sync;
    assign sync_int    = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clock_div_chan #(
            .DIV_WIDTH (DIV_WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .div     (div[i*DIV_WIDTH +: DIV_WIDTH]),
            .load    (load[i]),
            .sync    (sync_int),
            .busy    (busy[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
